branch_resolve_unit: RTL and testbench

- Consumes the branch comparator flags (equal, signed less-than, unsigned less-than) together with the decoded branch or jump from EX.
- Resolves taken/not-taken and computes the target.
- Owns the architectural PC register that drives fetch.
- Redirects the PC, flushes younger stages for a fixed window, produces the JAL/JALR link address, and traps on a misaligned target.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/branch_cond.sv | 33 +++
 rtl/branch_resolve_unit.sv | 143 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I branch definitions: widths, funct3 encodings, resolve FSM states
// and the default PC vectors.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        TRAP  = 2'd2
    } brs_state_e;

endpackage

// File: rtl/branch_cond.sv
// Combinational taken/not-taken decision for RV32I branches and jumps.
// Jumps are always taken; undefined branch funct3 codes are never taken.
module branch_cond
    import riscv_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_is_jal,
    input  logic       i_is_jalr,
    input  logic       i_cmp_eq,
    input  logic       i_cmp_lt,
    input  logic       i_cmp_ltu,
    output logic       o_taken
);

    // Select the comparator flag (or its inverse) named by funct3.
    always_comb begin
        o_taken = 1'b0;
        if (i_is_jal || i_is_jalr) begin
            o_taken = 1'b1;
        end else begin
            case (i_funct3)
                F3_BEQ:  o_taken = i_cmp_eq;
                F3_BNE:  o_taken = !i_cmp_eq;
                F3_BLT:  o_taken = i_cmp_lt;
                F3_BGE:  o_taken = !i_cmp_lt;
                F3_BLTU: o_taken = i_cmp_ltu;
                F3_BGEU: o_taken = !i_cmp_ltu;
                default: o_taken = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: owns the fetch PC, resolves EX branches/jumps,
// redirects fetch, holds flush for a fixed window, produces the link address
// and traps on misaligned targets.
module branch_resolve_unit #(
    parameter int               XLEN         = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_VECTOR = riscv_pkg::RESET_VECTOR_DEF,
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = riscv_pkg::TRAP_VECTOR_DEF,
    parameter int               FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [2:0]      br_funct3,
    input  logic            br_is_jal,
    input  logic            br_is_jalr,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_imm,
    input  logic [XLEN-1:0] br_rs1,
    input  logic            cmp_eq,
    input  logic            cmp_lt,
    input  logic            cmp_ltu,
    output logic [XLEN-1:0] pc,
    output logic            flush,
    output logic [XLEN-1:0] link_addr,
    output logic            link_valid,
    output logic            misalign_trap,
    output logic [XLEN-1:0] trap_pc
);
    import riscv_pkg::*;

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

    brs_state_e      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic [XLEN-1:0] r_link_addr, w_link_addr_nxt;
    logic            r_link_valid, w_link_valid_nxt;
    logic [XLEN-1:0] r_trap_pc, w_trap_pc_nxt;

    logic            w_taken;
    logic            w_accept;
    logic            w_is_jump;
    logic [XLEN-1:0] w_target;
    logic            w_misalign;

    branch_cond u_cond (
        .i_funct3  (br_funct3),
        .i_is_jal  (br_is_jal),
        .i_is_jalr (br_is_jalr),
        .i_cmp_eq  (cmp_eq),
        .i_cmp_lt  (cmp_lt),
        .i_cmp_ltu (cmp_ltu),
        .o_taken   (w_taken)
    );

    assign br_ready      = (r_state == RUN);
    assign flush         = (r_state != RUN);
    assign misalign_trap = (r_state == TRAP);
    assign pc            = r_pc;
    assign link_addr     = r_link_addr;
    assign link_valid    = r_link_valid;
    assign trap_pc       = r_trap_pc;

    assign w_accept  = br_valid && br_ready;
    assign w_is_jump = br_is_jal || br_is_jalr;

    // Target address; JALR clears bit 0 so only bit 1 can make it misaligned.
    always_comb begin
        w_target = br_pc + br_imm;
        if (br_is_jalr) begin
            w_target = (br_rs1 + br_imm) & ~XLEN'(1);
        end
        w_misalign = w_taken && (w_target[1:0] != 2'b00);
    end

    // Next-state, PC, link and trap bookkeeping; a taken accept overrides stall.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_pc_nxt         = r_pc;
        w_link_addr_nxt  = r_link_addr;
        w_link_valid_nxt = 1'b0;
        w_trap_pc_nxt    = r_trap_pc;
        case (r_state)
            RUN: begin
                if (w_accept && w_taken) begin
                    w_cnt_nxt = CNT_INIT;
                    if (w_misalign) begin
                        w_pc_nxt      = TRAP_VECTOR;
                        w_trap_pc_nxt = br_pc;
                        w_state_nxt   = TRAP;
                    end else begin
                        w_pc_nxt    = w_target;
                        w_state_nxt = FLUSH;
                        if (w_is_jump) begin
                            w_link_addr_nxt  = br_pc + XLEN'(4);
                            w_link_valid_nxt = 1'b1;
                        end
                    end
                end else if (!stall) begin
                    w_pc_nxt = r_pc + XLEN'(4);
                end
            end
            FLUSH: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RUN;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            TRAP: begin
                // Counter was already loaded when the trap was taken.
                w_state_nxt = FLUSH;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // State and architectural registers; reset dominates every other input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= RUN;
            r_cnt        <= '0;
            r_pc         <= RESET_VECTOR;
            r_link_addr  <= '0;
            r_link_valid <= 1'b0;
            r_trap_pc    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_pc         <= w_pc_nxt;
            r_link_addr  <= w_link_addr_nxt;
            r_link_valid <= w_link_valid_nxt;
            r_trap_pc    <= w_trap_pc_nxt;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus a
// randomized run against a cycle-level reference model.
module tb_branch_resolve_unit;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        br_valid;
    logic        br_ready;
    logic [2:0]  br_funct3;
    logic        br_is_jal;
    logic        br_is_jalr;
    logic [31:0] br_pc;
    logic [31:0] br_imm;
    logic [31:0] br_rs1;
    logic        cmp_eq;
    logic        cmp_lt;
    logic        cmp_ltu;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] link_addr;
    logic        link_valid;
    logic        misalign_trap;
    logic [31:0] trap_pc;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: busy = number of cycles fetch is still squashed.
    logic [31:0] m_pc, m_link_addr, m_trap_pc;
    logic        m_link_valid, m_trap;
    int          m_busy;

    branch_resolve_unit #(
        .XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .FLUSH_CYCLES(FC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .br_valid(br_valid), .br_ready(br_ready),
        .br_funct3(br_funct3), .br_is_jal(br_is_jal), .br_is_jalr(br_is_jalr),
        .br_pc(br_pc), .br_imm(br_imm), .br_rs1(br_rs1),
        .cmp_eq(cmp_eq), .cmp_lt(cmp_lt), .cmp_ltu(cmp_ltu),
        .pc(pc), .flush(flush), .link_addr(link_addr), .link_valid(link_valid),
        .misalign_trap(misalign_trap), .trap_pc(trap_pc)
    );

    always #5 clk = ~clk;

    function automatic bit spec_taken(input logic [2:0] f3, input bit jal, input bit jalr,
                                      input bit eq, input bit lt, input bit ltu);
        if (jal || jalr) return 1'b1;
        case (f3)
            3'd0: return eq;
            3'd1: return !eq;
            3'd4: return lt;
            3'd5: return !lt;
            3'd6: return ltu;
            3'd7: return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] tgt;
        m_link_valid = 1'b0;
        m_trap       = 1'b0;
        if (!rst_n) begin
            m_pc = 32'h0; m_busy = 0; m_link_addr = 32'h0; m_trap_pc = 32'h0;
        end else if (m_busy > 0) begin
            m_busy--;
        end else if (br_valid && spec_taken(br_funct3, br_is_jal, br_is_jalr, cmp_eq, cmp_lt, cmp_ltu)) begin
            tgt = br_is_jalr ? ((br_rs1 + br_imm) & 32'hFFFF_FFFE) : (br_pc + br_imm);
            if (tgt[1:0] != 2'b00) begin
                m_pc = 32'h100; m_trap_pc = br_pc; m_busy = FC + 1; m_trap = 1'b1;
            end else begin
                m_pc = tgt; m_busy = FC;
                if (br_is_jal || br_is_jalr) begin
                    m_link_addr = br_pc + 32'd4; m_link_valid = 1'b1;
                end
            end
        end else if (!stall) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        br_valid = 0; br_funct3 = 3'd0; br_is_jal = 0; br_is_jalr = 0;
        br_pc = 0; br_imm = 0; br_rs1 = 0; cmp_eq = 0; cmp_lt = 0; cmp_ltu = 0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        rst_n = 0; stall = 0; idle_inputs();
        tick(); tick();
        n_checks++; if (pc !== 32'h0) $display("FAIL reset_pc got %h want %h", pc, 32'h0); else n_pass++;
        n_checks++; if (flush !== 1'b0) $display("FAIL reset_flush got %b want 0", flush); else n_pass++;
        n_checks++; if (br_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", br_ready); else n_pass++;
        n_checks++; if (link_valid !== 1'b0 || misalign_trap !== 1'b0) $display("FAIL reset_pulses got lv=%b mt=%b want 0 0", link_valid, misalign_trap); else n_pass++;
        n_checks++; if (link_addr !== 32'h0 || trap_pc !== 32'h0) $display("FAIL reset_regs got la=%h tp=%h want 0 0", link_addr, trap_pc); else n_pass++;
        rst_n = 1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp_pc = 32'd4 * i;
            n_checks++; if (pc !== exp_pc || flush !== 1'b0) $display("FAIL seq_pc got %h/%b want %h/0", pc, flush, exp_pc); else n_pass++;
        end
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (pc !== 32'hC) $display("FAIL stall_hold got %h want %h", pc, 32'hC); else n_pass++;
        end
        stall = 0;
    endtask

    task automatic test_beq();
        br_valid = 1; br_pc = 32'h40; br_imm = 32'h20; br_funct3 = 3'b000; cmp_eq = 1;
        tick();
        idle_inputs();
        n_checks++; if (pc !== 32'h60) $display("FAIL beq_pc got %h want %h", pc, 32'h60); else n_pass++;
        n_checks++; if (flush !== 1'b1 || br_ready !== 1'b0) $display("FAIL beq_flush1 got f=%b r=%b want 1 0", flush, br_ready); else n_pass++;
        tick();
        n_checks++; if (flush !== 1'b1 || pc !== 32'h60) $display("FAIL beq_flush2 got f=%b pc=%h want 1 60", flush, pc); else n_pass++;
        tick();
        n_checks++; if (flush !== 1'b0 || br_ready !== 1'b1) $display("FAIL beq_flush_end got f=%b r=%b want 0 1", flush, br_ready); else n_pass++;
        tick();
        n_checks++; if (pc !== 32'h64) $display("FAIL beq_resume got %h want %h", pc, 32'h64); else n_pass++;
    endtask

    task automatic test_not_taken();
        logic [31:0] p0;
        p0 = pc;
        br_valid = 1; br_pc = 32'h64; br_imm = 32'h40; br_funct3 = 3'b110; cmp_ltu = 0; cmp_eq = 1; cmp_lt = 1;
        tick();
        n_checks++; if (pc !== p0 + 32'd4 || flush !== 1'b0) $display("FAIL bltu_nt got %h/%b want %h/0", pc, flush, p0 + 32'd4); else n_pass++;
        br_funct3 = 3'b010; cmp_eq = 1; cmp_lt = 1; cmp_ltu = 1;
        tick();
        n_checks++; if (pc !== p0 + 32'd8 || flush !== 1'b0) $display("FAIL f3_010_nt got %h/%b want %h/0", pc, flush, p0 + 32'd8); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_jalr();
        br_valid = 1; br_is_jalr = 1; br_pc = 32'h80; br_rs1 = 32'h1001; br_imm = 32'h3;
        tick();
        idle_inputs();
        n_checks++; if (pc !== 32'h1004) $display("FAIL jalr_pc got %h want %h", pc, 32'h1004); else n_pass++;
        n_checks++; if (link_addr !== 32'h84 || link_valid !== 1'b1) $display("FAIL jalr_link got %h/%b want 84/1", link_addr, link_valid); else n_pass++;
        tick();
        n_checks++; if (link_valid !== 1'b0) $display("FAIL jalr_link_pulse got %b want 0", link_valid); else n_pass++;
        tick();
        br_valid = 1; br_is_jalr = 1; br_pc = 32'h90; br_rs1 = 32'h1000; br_imm = 32'h2;
        tick();
        idle_inputs();
        n_checks++; if (misalign_trap !== 1'b1 || trap_pc !== 32'h90) $display("FAIL trap_pulse got %b/%h want 1/90", misalign_trap, trap_pc); else n_pass++;
        n_checks++; if (pc !== 32'h100 || link_valid !== 1'b0) $display("FAIL trap_pc_redirect got %h/%b want 100/0", pc, link_valid); else n_pass++;
        n_checks++; if (flush !== 1'b1) $display("FAIL trap_flush1 got %b want 1", flush); else n_pass++;
        tick();
        n_checks++; if (misalign_trap !== 1'b0 || flush !== 1'b1) $display("FAIL trap_flush2 got mt=%b f=%b want 0 1", misalign_trap, flush); else n_pass++;
        tick();
        n_checks++; if (flush !== 1'b1 || pc !== 32'h100) $display("FAIL trap_flush3 got %b/%h want 1/100", flush, pc); else n_pass++;
        tick();
        n_checks++; if (flush !== 1'b0 || link_addr !== 32'h84) $display("FAIL trap_end got f=%b la=%h want 0 84", flush, link_addr); else n_pass++;
    endtask

    task automatic test_stall_redirect();
        stall = 1;
        br_valid = 1; br_funct3 = 3'b001; cmp_eq = 0; br_pc = 32'h200; br_imm = 32'hFFFF_FFF8;
        tick();
        idle_inputs();
        n_checks++; if (pc !== 32'h1F8 || flush !== 1'b1) $display("FAIL stall_redirect got %h/%b want 1f8/1", pc, flush); else n_pass++;
        tick();
        n_checks++; if (flush !== 1'b1) $display("FAIL stall_flush2 got %b want 1", flush); else n_pass++;
        tick();
        n_checks++; if (flush !== 1'b0 || pc !== 32'h1F8) $display("FAIL stall_flush_end got %b/%h want 0/1f8", flush, pc); else n_pass++;
        tick();
        n_checks++; if (pc !== 32'h1F8) $display("FAIL stall_hold2 got %h want 1f8", pc); else n_pass++;
        stall = 0;
    endtask

    task automatic test_reset_mid_flush();
        br_valid = 1; br_funct3 = 3'b000; cmp_eq = 1; br_pc = 32'h300; br_imm = 32'h10;
        tick();
        idle_inputs();
        n_checks++; if (flush !== 1'b1) $display("FAIL midrst_pre got %b want 1", flush); else n_pass++;
        rst_n = 0;
        tick();
        rst_n = 1;
        n_checks++; if (pc !== 32'h0 || flush !== 1'b0 || br_ready !== 1'b1) $display("FAIL midrst got pc=%h f=%b r=%b want 0 0 1", pc, flush, br_ready); else n_pass++;
    endtask

    task automatic test_wrap();
        br_valid = 1; br_is_jal = 1; br_pc = 32'h0; br_imm = 32'hFFFF_FFFC;
        tick();
        idle_inputs();
        n_checks++; if (pc !== 32'hFFFF_FFFC || link_addr !== 32'h4) $display("FAIL wrap_jal got %h/%h want fffffffc/4", pc, link_addr); else n_pass++;
        tick(); tick(); tick();
        n_checks++; if (pc !== 32'h0) $display("FAIL wrap_pc got %h want 0", pc); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] r;
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            stall = ($urandom_range(0, 2) == 0);
            br_valid = $urandom_range(0, 1);
            r = $urandom_range(0, 19);
            br_is_jal  = (r < 3);
            br_is_jalr = (r >= 3 && r < 6);
            br_funct3 = 3'($urandom_range(0, 7));
            cmp_eq = $urandom_range(0, 1); cmp_lt = $urandom_range(0, 1); cmp_ltu = $urandom_range(0, 1);
            r = $urandom; br_pc = {r[31:2], 2'b00};
            r = $urandom; br_rs1 = r;
            r = $urandom; br_imm = {{20{r[11]}}, r[11:0]};
            if ($urandom_range(0, 4) != 0) br_imm[1:0] = 2'b00;
            if (br_is_jalr && $urandom_range(0, 3) != 0) br_rs1[1:0] = 2'b00;
            tick();
            n_checks++; if (pc !== m_pc) $display("FAIL rnd_pc cyc %0d got %h want %h", i, pc, m_pc); else n_pass++;
            n_checks++; if (flush !== (m_busy > 0) || br_ready !== (m_busy == 0)) $display("FAIL rnd_flush cyc %0d got f=%b r=%b want busy=%0d", i, flush, br_ready, m_busy); else n_pass++;
            n_checks++; if (link_valid !== m_link_valid || link_addr !== m_link_addr) $display("FAIL rnd_link cyc %0d got %b/%h want %b/%h", i, link_valid, link_addr, m_link_valid, m_link_addr); else n_pass++;
            n_checks++; if (misalign_trap !== m_trap || trap_pc !== m_trap_pc) $display("FAIL rnd_trap cyc %0d got %b/%h want %b/%h", i, misalign_trap, trap_pc, m_trap, m_trap_pc); else n_pass++;
        end
        rst_n = 1; idle_inputs();
    endtask

    initial begin
        test_reset();
        test_beq();
        test_not_taken();
        test_jalr();
        test_stall_redirect();
        test_reset_mid_flush();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
